ifu_fetch: RTL
==============

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h80000000, is the PC loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; synchronous, active-low (rst==0 at posedge clk resets).
REQ-004 req_valid  output  1  instruction-memory read request valid.
REQ-005 req_ready  input  1  memory accepts request this cycle.
REQ-006 req_addr  output  32  request address (current PC).
REQ-007 rsp_valid  input  1  memory response valid; single-cycle pulse, no backpressure.
REQ-008 rsp_data  input  32  fetched instruction word.
REQ-009 rsp_err  input  1  access error, qualified by rsp_valid.
REQ-010 inst_valid  output  1  instruction available to decode.
REQ-011 inst_ready  input  1  decode consumes instruction this cycle.
REQ-012 inst  output  32  registered instruction word.
REQ-013 inst_pc  output  32  PC of inst.
REQ-014 redirect_valid  input  1  branch/jump redirect from execute.
REQ-015 redirect_pc  input  32  redirect target.
REQ-016 fault  output  1  sticky fetch fault.

Function
REQ-017 States: REQ, WAIT, OUT, FAULT; plus 1-bit drop flag; PC register.
REQ-018 REQ: req_valid=1, req_addr=pc; req_valid&req_ready -> WAIT.
REQ-019 WAIT: req_valid=0; rsp_valid with drop=0 and rsp_err=0 -> inst<=rsp_data, inst_pc<=pc, go OUT.
REQ-020 WAIT: rsp_valid with drop=1 -> discard data/err, clear drop, go REQ (pc already holds redirect target).
REQ-021 WAIT: rsp_valid, drop=0, rsp_err=1 -> FAULT.
REQ-022 OUT: inst_valid=1; inst, inst_pc stable until handshake; inst_valid&inst_ready -> pc<=pc+4 (mod 2^32), go REQ.
REQ-023 Minimum fetch latency: request accept cycle -> inst_valid one cycle after rsp_valid; back-to-back throughput one instruction per 3 cycles with zero-wait memory.
REQ-024 Redirect has priority over all other events except reset; pc<=redirect_pc in any non-FAULT state.
REQ-025 Redirect in REQ without handshake: stay REQ, req_addr switches to redirect_pc next cycle.
REQ-026 Redirect in REQ coinciding with req handshake: go WAIT with drop=1.
REQ-027 Redirect in WAIT without rsp_valid: drop<=1, stay WAIT; with rsp_valid same cycle: discard response, go REQ, drop stays 0.
REQ-028 Redirect in OUT: inst discarded (inst_valid=0 next cycle) even if inst_ready same cycle; go REQ.
REQ-029 redirect_pc[1:0]!=0 -> FAULT instead of fetch; pc still loads redirect_pc for debug.
REQ-030 FAULT: fault=1, req_valid=0, inst_valid=0; exits only via reset; redirects ignored.
REQ-031 Only one outstanding request at any time.

Reset
REQ-032 On rst==0: state=REQ, pc=RESET_PC, drop=0, inst=0, inst_pc=0, fault=0.
REQ-033 Outputs during/after reset cycle: req_valid=1, req_addr=RESET_PC, inst_valid=0, fault=0.
REQ-034 Reset mid-WAIT: late rsp_valid arriving while state=REQ or after reset is ignored (no capture outside WAIT).
REQ-035 Reset overrides simultaneous redirect.

Verification
REQ-036 Reset release, req_ready=1, rsp_valid next cycle with 32'h00000413 -> req_addr 80000000, inst=00000413, inst_pc=80000000, inst_valid=1.
REQ-037 inst_ready held 0 for 5 cycles in OUT -> inst/inst_pc stable, no new request; then ready=1 -> next req_addr 80000004.
REQ-038 Redirect to 80000100 in WAIT, response 32'hDEADBEEF arrives 2 cycles later -> response dropped, next req_addr 80000100, no inst_valid for DEADBEEF.
REQ-039 Redirect to 80000200 in OUT with inst_ready=1 same cycle -> inst not counted consumed, next req_addr 80000200.
REQ-040 rsp_err=1 in WAIT, or redirect_pc=80000002 -> fault=1 sticky, req_valid=0 until rst==0.
REQ-041 pc=FFFFFFFC consumed -> next req_addr 00000000 (wrap).

Source files
------------

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch unit: issues a request at pc, waits for the
// response, holds the word for decode, and handles redirects, drops and sticky faults.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h80000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_OUT   = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic        r_drop;
  logic        w_drop_next;
  logic        w_capture;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        w_redirect_bad;

  assign w_redirect_bad = (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Redirect outranks every other event; a misaligned target faults but is still
  // latched into pc so it can be inspected on req_addr.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_drop_next  = r_drop;
    w_capture    = 1'b0;
    case (r_state)
      S_REQ: begin
        if (redirect_valid) begin
          w_pc_next = redirect_pc;
          if (w_redirect_bad) begin
            w_state_next = S_FAULT;
          end else if (req_ready) begin
            w_state_next = S_WAIT;
            w_drop_next  = 1'b1;
          end
        end else if (req_ready) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_pc_next = redirect_pc;
          if (w_redirect_bad) begin
            w_state_next = S_FAULT;
          end else if (rsp_valid) begin
            w_state_next = S_REQ;
            w_drop_next  = 1'b0;
          end else begin
            w_drop_next = 1'b1;
          end
        end else if (rsp_valid) begin
          if (r_drop) begin
            w_state_next = S_REQ;
            w_drop_next  = 1'b0;
          end else if (rsp_err) begin
            w_state_next = S_FAULT;
          end else begin
            w_state_next = S_OUT;
            w_capture    = 1'b1;
          end
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          w_pc_next    = redirect_pc;
          w_state_next = w_redirect_bad ? S_FAULT : S_REQ;
        end else if (inst_ready) begin
          w_pc_next    = r_pc + 32'd4;
          w_state_next = S_REQ;
        end
      end
      default: begin
        w_state_next = S_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc      <= RESET_PC;
      r_drop    <= 1'b0;
      r_inst    <= 32'd0;
      r_inst_pc <= 32'd0;
    end else begin
      r_pc   <= w_pc_next;
      r_drop <= w_drop_next;
      if (w_capture) begin
        r_inst    <= rsp_data;
        r_inst_pc <= r_pc;
      end
    end
  end

  always_comb begin
    req_valid  = (r_state == S_REQ);
    inst_valid = (r_state == S_OUT);
    fault      = (r_state == S_FAULT);
    req_addr   = r_pc;
    inst       = r_inst;
    inst_pc    = r_inst_pc;
  end

endmodule
